seq_data_mem: RTL and testbench
===============================

Name: seq_data_mem

Overview:
- Data-memory responder for the `seq_core` load/store port; the slave end of the core's `read`/`write`/`address`/`data_in`/`data_out` interface.
- Single-port word RAM with registered read data and a post-reset initialisation sweep.
- Reports protocol and address faults through sticky flags.
- Sits beside the core at top level; ports connect by name to the core's memory signals.

Parameters:
- A_SIZE, 10, address width; matches the core.
- D_SIZE, 32, data word width; matches the core.
- DEPTH, 128, implemented words (must be <= 2^A_SIZE); higher addresses are out of range.
- INIT_MODE, 1, post-reset fill pattern: 0 = all zero, 1 = word i holds i (zero-extended/truncated to D_SIZE).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- read  input  1  core read strobe.
- write  input  1  core write strobe.
- address  input  A_SIZE  word address from the core.
- data_out  input  D_SIZE  write data from the core (core-side name).
- data_in  output  D_SIZE  read data to the core (core-side name), registered.
- busy  output  1  high while the init sweep runs; accesses are ignored.
- err_conflict  output  1  sticky: read and write asserted in the same cycle.
- err_range  output  1  sticky: access with address >= DEPTH.

Behaviour:
- Reset: one clock synchronous and active-high.
  - Clock port `clk`, reset port `rst`; polarity and synchronicity are fixed.
  - On a reset edge: FSM goes to INIT, init counter = 0, data_in = 0, busy = 1, err_conflict = 0, err_range = 0.
- FSM states:
  - INIT: each cycle, write the fill value to mem[counter] and increment the counter.
    - After the edge that writes word DEPTH-1, go to READY; busy drops to 0 on that edge.
    - Total INIT duration is exactly DEPTH cycles after rst deasserts.
  - READY: normal operation; it is only left through rst.
- Read (READY, read=1, write=0, address<DEPTH):
  - data_in <= mem[address] on that edge.
  - Core samples data_in the following cycle (1-cycle latency).
  - data_in holds its value until the next valid read.
- Write (READY, write=1, read=0, address<DEPTH):
  - mem[address] <= data_out on that edge; data_in unchanged.
  - A read of the same address in the next cycle returns the new value.
- Conflict (read=1 and write=1): no memory update, data_in unchanged, err_conflict <= 1.
- Out of range (address >= DEPTH with a single strobe):
  - A read loads data_in <= 0; a write is dropped.
  - err_range <= 1.
  - If a conflict and out-of-range address coincide, both flags set.
- Idle (read=0, write=0): no state change.
- Accesses during INIT are silently ignored: no flags, data_in stays 0.
- Both error flags are sticky until rst.
- Reset mid-operation (rst in READY) restarts INIT; every word is re-filled over DEPTH cycles and any earlier writes are lost.
- rst held high for multiple cycles keeps the counter at 0 and busy = 1.
- Init counter width: $clog2(DEPTH)+1 bits; no wrap-around occurs.

Optional Feature:
- Macro: SEQ_DATA_MEM_STATS_EN.
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - They count completed valid reads and writes in READY: in-range, single strobe.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package seq_data_mem_pkg holds:
  - the FSM state type (ST_INIT, ST_READY);
  - INIT_ZERO = 0 and INIT_INDEX = 1 constants;
  - the stats counter width constant (16).
- One sub-module, seq_data_mem_init, owns the INIT/READY FSM and the sweep counter.
  - It outputs busy, init_we, init_addr and init_data.
  - The top level muxes init writes against core writes into the array.

Test Plan (A_SIZE=10, D_SIZE=32, DEPTH=128, INIT_MODE=1):
1. Pulse rst for 1 cycle -> busy=1 for exactly 128 cycles then 0; read address 5 -> data_in=32'd5 one cycle later; read 127 -> 32'd127.
2. In READY, write address 7 with data_out=32'hDEADBEEF, then read 7 next cycle -> data_in=32'hDEADBEEF; read 8 -> 32'd8.
3. Assert read=1 and write=1 at address 3 with data_out=32'h55 -> err_conflict=1, data_in unchanged; a later read of 3 returns 32'd3.
4. Read address 200 -> data_in=0, err_range=1. Write address 500 with data_out=32'hFF, then read 500 mod 128 = 116 -> 32'd116.
5. Write address 7 with 32'h1234, then rst mid-READY; after 128 busy cycles, read 7 -> 32'd7; both flags cleared; accesses issued during busy produce no flag.
6. With SEQ_DATA_MEM_STATS_EN defined: 3 valid reads, 2 valid writes, 1 conflict, 1 out-of-range read -> rd_count=3, wr_count=2.

Source files
------------

// File: rtl/seq_data_mem_pkg.sv
// Shared types and constants for the seq_core data memory.
// No logic; imported by seq_data_mem and seq_data_mem_init.
package seq_data_mem_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;
    localparam int STATS_W    = 16;

endpackage

// File: rtl/seq_data_mem_init.sv
// Post-reset fill sequencer: owns the INIT/READY FSM and the sweep counter.
// Latency: DEPTH cycles of busy after rst drops, one word per cycle.
// Backpressure: none; the core is simply ignored while busy is high.
module seq_data_mem_init
    import seq_data_mem_pkg::*;
#(
    parameter int DEPTH     = 128,
    parameter int D_SIZE    = 32,
    parameter int INIT_MODE = 1,
    parameter int IW        = 7
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_busy,
    output logic              o_init_we,
    output logic [IW-1:0]     o_init_addr,
    output logic [D_SIZE-1:0] o_init_data
);

    // One spare bit so the counter can step past DEPTH-1 without wrapping.
    localparam int             CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(DEPTH - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_state <= ST_READY;
                r_busy  <= 1'b0;
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_init_we   = (r_state == ST_INIT);
    assign o_init_addr = IW'(r_cnt);
    assign o_init_data = (INIT_MODE == INIT_INDEX) ? D_SIZE'(r_cnt) : '0;

endmodule

// File: rtl/seq_data_mem.sv
// Data memory for seq_core with registered read data and sticky fault flags.
// Latency: 1 cycle read; no backpressure, accesses while busy are dropped.
// SEQ_DATA_MEM_STATS_EN adds saturating rd_count/wr_count outputs.
module seq_data_mem
    import seq_data_mem_pkg::*;
#(
    parameter int A_SIZE    = 10,
    parameter int D_SIZE    = 32,
    parameter int DEPTH     = 128,
    parameter int INIT_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [A_SIZE-1:0] address,
    input  logic [D_SIZE-1:0] data_out,
    output logic [D_SIZE-1:0] data_in,
    output logic              busy,
    output logic              err_conflict,
    output logic              err_range
`ifdef SEQ_DATA_MEM_STATS_EN
    ,
    output logic [STATS_W-1:0] rd_count,
    output logic [STATS_W-1:0] wr_count
`endif
);

    localparam int                IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [A_SIZE:0]   DEPTH_A = (A_SIZE + 1)'(DEPTH);

    logic              w_busy;
    logic              w_init_we;
    logic [IW-1:0]     w_init_addr;
    logic [D_SIZE-1:0] w_init_data;
    logic [IW-1:0]     w_idx;
    logic              w_in_range;
    logic              w_rd_ok;
    logic              w_wr_ok;

    logic [D_SIZE-1:0] r_mem [DEPTH];
    logic [D_SIZE-1:0] r_data_in;
    logic              r_err_conflict;
    logic              r_err_range;

    seq_data_mem_init #(
        .DEPTH     (DEPTH),
        .D_SIZE    (D_SIZE),
        .INIT_MODE (INIT_MODE),
        .IW        (IW)
    ) u_init (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_busy      (w_busy),
        .o_init_we   (w_init_we),
        .o_init_addr (w_init_addr),
        .o_init_data (w_init_data)
    );

    assign w_idx      = address[IW-1:0];
    assign w_in_range = ({1'b0, address} < DEPTH_A);
    assign w_rd_ok    = !w_busy && read && !write && w_in_range;
    assign w_wr_ok    = !w_busy && write && !read && w_in_range;

    // Sweep and core writes never overlap: busy covers the whole INIT state.
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            r_mem[w_init_addr] <= w_init_data;
        end else if (w_wr_ok) begin
            r_mem[w_idx] <= data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_in      <= '0;
            r_err_conflict <= 1'b0;
            r_err_range    <= 1'b0;
        end else if (!w_busy) begin
            if (read && write) begin
                r_err_conflict <= 1'b1;
            end
            if ((read || write) && !w_in_range) begin
                r_err_range <= 1'b1;
            end
            if (w_rd_ok) begin
                r_data_in <= r_mem[w_idx];
            end else if (read && !write && !w_in_range) begin
                r_data_in <= '0;
            end
        end
    end

    assign data_in      = r_data_in;
    assign busy         = w_busy;
    assign err_conflict = r_err_conflict;
    assign err_range    = r_err_range;

`ifdef SEQ_DATA_MEM_STATS_EN
    logic [STATS_W-1:0] r_rd_count;
    logic [STATS_W-1:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (w_rd_ok && (r_rd_count != '1)) begin
                r_rd_count <= r_rd_count + 1'b1;
            end
            if (w_wr_ok && (r_wr_count != '1)) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_seq_data_mem.sv
// Self-checking bench for seq_data_mem: directed plan steps plus random traffic
// compared against an array-based behavioural model.
module tb_seq_data_mem;
    import seq_data_mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        read;
    logic        write;
    logic [9:0]  address;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        busy;
    logic        err_conflict;
    logic        err_range;
`ifdef SEQ_DATA_MEM_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    seq_data_mem #(
        .A_SIZE    (10),
        .D_SIZE    (32),
        .DEPTH     (128),
        .INIT_MODE (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .read         (read),
        .write        (write),
        .address      (address),
        .data_out     (data_out),
        .data_in      (data_in),
        .busy         (busy),
        .err_conflict (err_conflict),
        .err_range    (err_range)
`ifdef SEQ_DATA_MEM_STATS_EN
        ,
        .rd_count     (rd_count),
        .wr_count     (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: contents, busy cycles remaining, outputs, counters.
    logic [31:0] m_mem [0:127];
    int          m_busy_left;
    logic [31:0] m_din;
    logic        m_conf;
    logic        m_range;
    int          m_rd;
    int          m_wr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rs, input logic r, input logic w,
                              input logic [9:0] a, input logic [31:0] d);
        if (rs) begin
            for (int i = 0; i < 128; i++) m_mem[i] = 32'(i);
            m_busy_left = 128;
            m_din   = 0;
            m_conf  = 0;
            m_range = 0;
            m_rd    = 0;
            m_wr    = 0;
        end else if (m_busy_left > 0) begin
            m_busy_left--;
        end else begin
            if (r && w) m_conf = 1;
            if ((r || w) && a >= 10'd128) m_range = 1;
            if (r != w) begin
                if (a < 10'd128) begin
                    if (r) begin
                        m_din = m_mem[a[6:0]];
                        if (m_rd < 65535) m_rd++;
                    end else begin
                        m_mem[a[6:0]] = d;
                        if (m_wr < 65535) m_wr++;
                    end
                end else if (r) begin
                    m_din = 0;
                end
            end
        end
    endtask

    task automatic tick(input logic rs, input logic r, input logic w,
                        input logic [9:0] a, input logic [31:0] d);
        rst = rs; read = r; write = w; address = a; data_out = d;
        @(posedge clk);
        model_step(rs, r, w, a, d);
        #1;
        check("data_in", data_in, m_din);
        check("busy", 32'(busy), 32'(m_busy_left > 0));
        check("err_conflict", 32'(err_conflict), 32'(m_conf));
        check("err_range", 32'(err_range), 32'(m_range));
`ifdef SEQ_DATA_MEM_STATS_EN
        check("rd_count", 32'(rd_count), 32'(m_rd));
        check("wr_count", 32'(wr_count), 32'(m_wr));
`endif
    endtask

    task automatic rand_tick();
        logic [9:0] a;
        a = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, 127)) : 10'($urandom_range(0, 1023));
        tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    endtask

    initial begin
        rst = 1'b1; read = 1'b0; write = 1'b0; address = '0; data_out = '0;
        m_busy_left = 0; m_din = 0; m_conf = 0; m_range = 0; m_rd = 0; m_wr = 0;

        // Reset and the full 128-cycle sweep, with core traffic that must be ignored.
        tick(1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_data_in", data_in, 32'd0);
        for (int i = 0; i < 128; i++) rand_tick();
        check("init_done", 32'(busy), 32'd0);

        tick(1'b0, 1'b1, 1'b0, 10'd5, 32'd0);
        check("rd5", data_in, 32'd5);
        tick(1'b0, 1'b1, 1'b0, 10'd127, 32'd0);
        check("rd127", data_in, 32'd127);

        tick(1'b0, 1'b0, 1'b1, 10'd7, 32'hDEADBEEF);
        tick(1'b0, 1'b1, 1'b0, 10'd7, 32'd0);
        check("rd7_new", data_in, 32'hDEADBEEF);
        tick(1'b0, 1'b1, 1'b0, 10'd8, 32'd0);
        check("rd8", data_in, 32'd8);

        tick(1'b0, 1'b1, 1'b1, 10'd3, 32'h55);
        check("conf_flag", 32'(err_conflict), 32'd1);
        check("conf_hold", data_in, 32'd8);
        tick(1'b0, 1'b1, 1'b0, 10'd3, 32'd0);
        check("rd3", data_in, 32'd3);

        tick(1'b0, 1'b1, 1'b0, 10'd200, 32'd0);
        check("oor_rd", data_in, 32'd0);
        check("oor_flag", 32'(err_range), 32'd1);
        tick(1'b0, 1'b0, 1'b1, 10'd500, 32'hFF);
        tick(1'b0, 1'b1, 1'b0, 10'd116, 32'd0);
        check("rd116", data_in, 32'd116);

        for (int i = 0; i < 400; i++) rand_tick();

        // Reset mid-operation, held for several cycles, then a fresh sweep.
        tick(1'b0, 1'b0, 1'b1, 10'd7, 32'h1234);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
        for (int i = 0; i < 128; i++) rand_tick();
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_conf", 32'(err_conflict), 32'd0);
        check("rst2_range", 32'(err_range), 32'd0);
        tick(1'b0, 1'b1, 1'b0, 10'd7, 32'd0);
        check("rst2_rd7", data_in, 32'd7);

        tick(1'b0, 1'b1, 1'b0, 10'd9, 32'd0);
        tick(1'b0, 1'b1, 1'b0, 10'd10, 32'd0);
        tick(1'b0, 1'b0, 1'b1, 10'd20, 32'hA5A5);
        tick(1'b0, 1'b0, 1'b1, 10'd21, 32'h5A5A);
        tick(1'b0, 1'b1, 1'b1, 10'd22, 32'h1);
        tick(1'b0, 1'b1, 1'b0, 10'd300, 32'd0);
`ifdef SEQ_DATA_MEM_STATS_EN
        check("stats_rd", 32'(rd_count), 32'd3);
        check("stats_wr", 32'(wr_count), 32'd2);
`endif
        tick(1'b0, 1'b1, 1'b0, 10'd20, 32'd0);
        check("rd20", data_in, 32'hA5A5);

        for (int i = 0; i < 300; i++) rand_tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
